// File: rtl/gb_bus_bridge.sv
// gb_bus_bridge: Avalon-MM slave giving Nios access to the Game Boy bus.
// Posted writes via FIFO, ordered blocking reads, timed bus cycles.
//
// Ports:
//   clk_clk, reset_reset_n        clock, async active-low reset
//   avs_address/read/write        Avalon request (word address)
//   avs_writedata, avs_readdata   Avalon data
//   avs_waitrequest               combinational stall
//   gb_address_export, gb_dout_export, gb_din_export
//                                 Game Boy bus address/data
//   gb_rd_n, gb_wr_n              registered active-low strobes
//   fifo_level                    posted writes pending
//   busy                          FSM active or writes pending
module gb_bus_bridge #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [ADDR_W-1:0]             avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [DATA_W-1:0]             avs_writedata,
  output logic [DATA_W-1:0]             avs_readdata,
  output logic                          avs_waitrequest,
  output logic [ADDR_W-1:0]             gb_address_export,
  output logic [DATA_W-1:0]             gb_dout_export,
  input  logic [DATA_W-1:0]             gb_din_export,
  output logic                          gb_rd_n,
  output logic                          gb_wr_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = 4;

  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WC       = CW'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_SETUP,
    RD_STROBE,
    RD_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     wc_q, wc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;

  logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;

  logic push;
  logic pop;
  logic empty;

  // Full is registered, so a pop only frees a slot one cycle later.
  assign empty = (cnt_q == '0);
  assign push  = avs_write & ~full_q;
  assign pop   = (state_q == IDLE) & ~empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = rp_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == FULL_LVL);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fa_q[i] <= '0;
        fd_q[i] <= '0;
      end
    end else if (push) begin
      fa_q[wp_q] <= avs_address;
      fd_q[wp_q] <= avs_writedata;
    end
  end

  // Draining the FIFO first keeps reads ordered behind posted writes.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = WR_SETUP;
          addr_d  = fa_q[rp_q];
          dout_d  = fd_q[rp_q];
        end else if (avs_read && !avs_write) begin
          state_d = RD_SETUP;
          addr_d  = avs_address;
        end
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        wc_d    = WC;
      end
      WR_STROBE: begin
        if (wc_q == '0) begin
          state_d = WR_HOLD;
        end else begin
          wc_d = wc_q - CW'(1);
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
      end
      RD_SETUP: begin
        state_d = RD_STROBE;
        wc_d    = WC;
      end
      RD_STROBE: begin
        if (wc_q == '0) begin
          state_d = RD_DONE;
          rdata_d = gb_din_export;
        end else begin
          wc_d = wc_q - CW'(1);
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state and registered,
  // so they line up with the state and cannot glitch.
  assign wr_n_d = (state_d != WR_STROBE);
  assign rd_n_d = (state_d != RD_STROBE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      wc_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
    end
  end

  // Any request seen while reset is held must stall.
  assign avs_waitrequest =
    (~reset_reset_n & (avs_read | avs_write)) |
    (avs_write & full_q) |
    (avs_read & ~avs_write & (state_q != RD_DONE));

  assign avs_readdata      = rdata_q;
  assign gb_address_export = addr_q;
  assign gb_dout_export    = dout_q;
  assign gb_rd_n           = rd_n_q;
  assign gb_wr_n           = wr_n_q;
  assign fifo_level        = cnt_q;
  assign busy              = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_gb_bus_bridge.sv
// tb_gb_bus_bridge: self-checking bench for gb_bus_bridge.
// Two instances: default widths/W=2 and ADDR 20/DATA 16/W=0.
module tb_gb_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic [19:0] avs_addr;
  logic [15:0] avs_wdata;
  logic        avs_rd;
  logic        avs_wr;
  logic [15:0] gb_din = '0;

  logic [7:0]  rdata0, dout0;
  logic [15:0] addr0;
  logic        wait0, rd_n0, wr_n0, busy0;
  logic [2:0]  lvl0;

  logic [15:0] rdata1, dout1;
  logic [19:0] addr1;
  logic        wait1, rd_n1, wr_n1, busy1;
  logic [2:0]  lvl1;

  gb_bus_bridge #(
    .ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2), .FIFO_DEPTH(4)
  ) u_dut0 (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .avs_address      (avs_addr[15:0]),
    .avs_read         (avs_rd & ~sel),
    .avs_write        (avs_wr & ~sel),
    .avs_writedata    (avs_wdata[7:0]),
    .avs_readdata     (rdata0),
    .avs_waitrequest  (wait0),
    .gb_address_export(addr0),
    .gb_dout_export   (dout0),
    .gb_din_export    (gb_din[7:0]),
    .gb_rd_n          (rd_n0),
    .gb_wr_n          (wr_n0),
    .fifo_level       (lvl0),
    .busy             (busy0)
  );

  gb_bus_bridge #(
    .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0), .FIFO_DEPTH(4)
  ) u_dut1 (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .avs_address      (avs_addr),
    .avs_read         (avs_rd & sel),
    .avs_write        (avs_wr & sel),
    .avs_writedata    (avs_wdata),
    .avs_readdata     (rdata1),
    .avs_waitrequest  (wait1),
    .gb_address_export(addr1),
    .gb_dout_export   (dout1),
    .gb_din_export    (gb_din),
    .gb_rd_n          (rd_n1),
    .gb_wr_n          (wr_n1),
    .fifo_level       (lvl1),
    .busy             (busy1)
  );

  logic [19:0] m_addr;
  logic [15:0] m_dout, m_rdata;
  logic        m_wait, m_rd_n, m_wr_n, m_busy;
  logic [2:0]  m_lvl;

  assign m_addr  = sel ? addr1  : {4'b0, addr0};
  assign m_dout  = sel ? dout1  : {8'b0, dout0};
  assign m_rdata = sel ? rdata1 : {8'b0, rdata0};
  assign m_wait  = sel ? wait1  : wait0;
  assign m_rd_n  = sel ? rd_n1  : rd_n0;
  assign m_wr_n  = sel ? wr_n1  : wr_n0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_lvl   = sel ? lvl1   : lvl0;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic tmo(input string nm);
    checks++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Avalon-level reference: what each address should read back as,
  // and the order bus writes must appear in.
  int dmask = 'hFF;
  int wc    = 2;
  int mdl[int];
  int bus_mem[int];

  function automatic int dflt(input int a);
    return (a * 37 + 11) & dmask;
  endfunction

  function automatic int bus_val(input int a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return dflt(a);
  endfunction

  typedef struct { int a; int d; int len; bit ok; } bw_t;
  typedef struct { int a; int d; } ew_t;
  typedef struct { int a; int len; bit ok; } br_t;

  bw_t obs_wr[$];
  ew_t exp_wr[$];
  br_t obs_rd[$];
  int  exp_rd[$];

  int cyc = 0, both_low = 0, lvl_max = 0;
  int wr_falls = 0, rd_falls = 0;
  int last_hold = 0, rd_fall_cyc = 0;
  int w_a, w_d, wlen, r_a, rlen, p_a, p_d;
  bit w_ok, r_ok;
  bit p_wr_n = 1'b1, p_rd_n = 1'b1;

  // Bus-side peripheral model and strobe monitor.
  always @(negedge clk) begin
    int a, d;
    a = int'(m_addr);
    d = int'(m_dout);
    cyc++;
    if (int'(m_lvl) > lvl_max) lvl_max = int'(m_lvl);
    if (!m_wr_n && !m_rd_n) both_low++;
    if (!m_wr_n) begin
      bus_mem[a] = d;
      if (p_wr_n) begin
        wr_falls++;
        w_a = a; w_d = d; wlen = 1;
        w_ok = (a == p_a) && (d == p_d);
      end else begin
        wlen++;
        if (a != w_a || d != w_d) w_ok = 1'b0;
      end
    end else if (!p_wr_n) begin
      if (a != w_a || d != w_d) w_ok = 1'b0;
      obs_wr.push_back('{w_a, w_d, wlen, w_ok});
      last_hold = cyc;
    end
    if (!m_rd_n) begin
      if (p_rd_n) begin
        rd_falls++;
        r_a = a; rlen = 1; rd_fall_cyc = cyc;
        r_ok = (a == p_a);
      end else begin
        rlen++;
        if (a != r_a) r_ok = 1'b0;
      end
    end else if (!p_rd_n) begin
      if (a != r_a) r_ok = 1'b0;
      obs_rd.push_back('{r_a, rlen, r_ok});
    end
    p_wr_n = m_wr_n;
    p_rd_n = m_rd_n;
    p_a = a;
    p_d = d;
    gb_din = 16'(bus_val(a));
  end

  task automatic do_write(input int a, input int d, output int waits);
    bit done;
    avs_addr = 20'(a);
    avs_wdata = 16'(d);
    avs_wr = 1'b1;
    waits = 0;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!m_wait) begin
        done = 1;
        break;
      end
      chk("full_when_wait", m_lvl, 4);
      waits++;
    end
    if (!done) tmo("write_accept");
    @(posedge clk);
    #1;
    avs_wr = 1'b0;
    mdl[a] = d;
    exp_wr.push_back('{a, d});
  endtask

  task automatic do_read(input int a, output int rd, output int lat);
    bit done;
    avs_addr = 20'(a);
    avs_rd = 1'b1;
    lat = 0;
    rd = -1;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!m_wait) begin
        rd = int'(m_rdata);
        done = 1;
        break;
      end
      lat++;
    end
    if (!done) tmo("read_done");
    @(posedge clk);
    #1;
    avs_rd = 1'b0;
    exp_rd.push_back(a);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!m_busy) begin
        done = 1;
        break;
      end
    end
    if (!done) tmo("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus();
    bw_t o;
    ew_t e;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (obs_wr.size() == 0) begin
        tmo("bus_wr_missing");
      end else begin
        o = obs_wr.pop_front();
        chk("bus_wr_addr", o.a, e.a);
        chk("bus_wr_data", o.d, e.d);
        chk("bus_wr_strobe_len", o.len, wc + 1);
        chk("bus_wr_stable", o.ok, 1);
      end
    end
    chk("bus_wr_extra", obs_wr.size(), 0);
  endtask

  task automatic check_rd();
    br_t o;
    int a;
    while (exp_rd.size() > 0) begin
      a = exp_rd.pop_front();
      if (obs_rd.size() == 0) begin
        tmo("bus_rd_missing");
      end else begin
        o = obs_rd.pop_front();
        chk("bus_rd_addr", o.a, a);
        chk("bus_rd_strobe_len", o.len, wc + 1);
        chk("bus_rd_stable", o.ok, 1);
      end
    end
    chk("bus_rd_extra", obs_rd.size(), 0);
  endtask

  task automatic clear_models();
    mdl.delete();
    bus_mem.delete();
    exp_wr.delete();
    obs_wr.delete();
    exp_rd.delete();
    obs_rd.delete();
  endtask

  task automatic rand_run(input int base, input int n);
    int a, d, w, rd, lat, exp;
    for (int i = 0; i < n; i++) begin
      a = base + int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) < 2) begin
        d = int'($urandom) & dmask;
        do_write(a, d, w);
      end else begin
        exp = mdl.exists(a) ? mdl[a] : dflt(a);
        do_read(a, rd, lat);
        chk("rand_rdata", rd, exp);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    check_bus();
    check_rd();
  endtask

  localparam int PK = 0;
  localparam int WR = 1;
  localparam int RD = 2;

  typedef struct { int k; int a; int d; int e; } vec_t;
  vec_t tbl[9];

  initial begin
    int w, rd, lat, sum, wf, rf;
    bit seen;

    tbl[0] = '{PK, 'hFF44, 'h90, 0};
    tbl[1] = '{RD, 'hFF44, 0, 'h90};
    tbl[2] = '{WR, 'hC000, 'h5A, 0};
    tbl[3] = '{RD, 'hC000, 0, 'h5A};
    tbl[4] = '{WR, 'hC001, 'hA5, 0};
    tbl[5] = '{WR, 'hC000, 'h3C, 0};
    tbl[6] = '{RD, 'hC000, 0, 'h3C};
    tbl[7] = '{RD, 'hC001, 0, 'hA5};
    tbl[8] = '{RD, 'h0042, 0, ('h42 * 37 + 11) & 'hFF};

    rst_n = 1'b0;
    sel = 1'b0;
    avs_addr = '0;
    avs_wdata = '0;
    avs_rd = 1'b0;
    avs_wr = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rd_n", m_rd_n, 1);
    chk("rst_wr_n", m_wr_n, 1);
    chk("rst_addr", m_addr, 0);
    chk("rst_dout", m_dout, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_level", m_lvl, 0);
    chk("rst_busy", m_busy, 0);
    avs_rd = 1'b1;
    #1 chk("rst_wait_rd", m_wait, 1);
    avs_rd = 1'b0;
    avs_wr = 1'b1;
    #1 chk("rst_wait_wr", m_wait, 1);
    avs_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      unique case (tbl[i].k)
        PK: bus_mem[tbl[i].a] = tbl[i].d;
        WR: begin
          do_write(tbl[i].a, tbl[i].d, w);
          chk("tbl_wr_accept_wait", w, 0);
          @(negedge clk);
          chk("tbl_wr_busy", m_busy, 1);
          wait_idle();
          chk("tbl_wr_idle", m_busy, 0);
          check_bus();
        end
        default: begin
          wait_idle();
          do_read(tbl[i].a, rd, lat);
          chk("tbl_rd_latency", lat, wc + 3);
          chk("tbl_rd_data", rd, tbl[i].e);
          wait_idle();
          check_rd();
        end
      endcase
    end

    lvl_max = 0;
    sum = 0;
    for (int i = 0; i < 6; i++) begin
      do_write('hC200 + i, 'h10 + i, w);
      sum += w;
    end
    chk("fill_level_max", lvl_max, 4);
    chk("fill_saw_wait", sum > 0, 1);
    wait_idle();
    check_bus();

    rf = rd_falls;
    avs_addr = 20'h0C300;
    avs_wdata = 16'h0077;
    avs_wr = 1'b1;
    avs_rd = 1'b1;
    @(negedge clk);
    chk("rw_wait", m_wait, 0);
    @(posedge clk);
    #1;
    avs_wr = 1'b0;
    avs_rd = 1'b0;
    mdl['hC300] = 'h77;
    exp_wr.push_back('{'hC300, 'h77});
    wait_idle();
    check_bus();
    chk("rw_read_ignored", rd_falls, rf);

    do_write('hD000, 'h11, w);
    do_write('hD000, 'h22, w);
    do_read('hD000, rd, lat);
    chk("raw_rdata", rd, 'h22);
    chk("raw_order", rd_fall_cyc > last_hold, 1);
    wait_idle();
    check_bus();
    check_rd();

    rand_run('hC100, 80);

    do_write('hC400, 1, w);
    do_write('hC401, 2, w);
    do_write('hC402, 3, w);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (!m_wr_n) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) tmo("rst_mid_strobe");
    chk("pre_rst_level", m_lvl, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_n", m_wr_n, 1);
    chk("mid_rst_level", m_lvl, 0);
    chk("mid_rst_busy", m_busy, 0);
    repeat (2) @(negedge clk);
    wf = wr_falls;
    rf = rd_falls;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_no_wr", wr_falls, wf);
    chk("post_rst_no_rd", rd_falls, rf);
    chk("post_rst_busy", m_busy, 0);
    clear_models();
    @(posedge clk);
    #1;

    sel = 1'b1;
    dmask = 'hFFFF;
    wc = 0;
    clear_models();
    wait_idle();
    do_write('hABCDE, 'hBEEF, w);
    chk("w0_wr_wait", w, 0);
    wait_idle();
    check_bus();
    do_read('hABCDE, rd, lat);
    chk("w0_rd_latency", lat, 3);
    chk("w0_rd_data", rd, 'hBEEF);
    wait_idle();
    do_read('h12345, rd, lat);
    chk("w0_rd_dflt", rd, dflt('h12345));
    wait_idle();
    check_rd();
    rand_run('h8A000, 80);

    chk("never_both_low", both_low, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
